// File: rtl/u_relu_pool.sv
// Purpose : ReLU plus 2x2 max-pooling of four PE-array row results into two pooled rows.
// Latency : poolVld rises 2 cycles after the dinVld cycle of the second beat of a pair.
// Backpressure: none; one beat per cycle in, one pooled pair per two beats out, bubbles allowed.
//
// Ports:
//   clk_cal, rst_cal        clock, synchronous active-high reset
//   din0..din3, dinVld      signed row results and their beat-valid strobe
//   rowStart                with dinVld, marks beat 0 of a row group
//   pool0, pool1, poolVld   pooled rows 0/1 and 2/3, single-cycle valid pulse
//   rowDone                 pulses with poolVld of the last pair of a row group
//   pairErr                 sticky flag: rowStart arrived while a half pair was pending
module u_relu_pool #(
    parameter int DATA_SIZE = 8,
    parameter int ROW_LEN   = 28
) (
    input  logic                 clk_cal,
    input  logic                 rst_cal,
    input  logic [DATA_SIZE-1:0] din0,
    input  logic [DATA_SIZE-1:0] din1,
    input  logic [DATA_SIZE-1:0] din2,
    input  logic [DATA_SIZE-1:0] din3,
    input  logic                 dinVld,
    input  logic                 rowStart,
    output logic [DATA_SIZE-1:0] pool0,
    output logic [DATA_SIZE-1:0] pool1,
    output logic                 poolVld,
    output logic                 rowDone,
    output logic                 pairErr
);

    localparam int CW = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(ROW_LEN - 1);

    // Signed maximum of two two's-complement words.
    function automatic logic [DATA_SIZE-1:0] smax(input logic [DATA_SIZE-1:0] a,
                                                  input logic [DATA_SIZE-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [DATA_SIZE-1:0] relu(input logic [DATA_SIZE-1:0] x);
        return x[DATA_SIZE-1] ? '0 : x;
    endfunction

    // Post-ReLU values are non-negative, so an unsigned compare is exact here.
    function automatic logic [DATA_SIZE-1:0] umax(input logic [DATA_SIZE-1:0] a,
                                                  input logic [DATA_SIZE-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_SIZE-1:0] v0, v1;
    logic                 s1_vld;
    logic                 s1_start;
    logic [DATA_SIZE-1:0] hold0, hold1;
    logic                 parity;
    logic [CW-1:0]        beat_cnt;

    // Stage 1: vertical max + ReLU; rowStart travels with its beat.
    always_ff @(posedge clk_cal) begin
        if (rst_cal) begin
            v0       <= '0;
            v1       <= '0;
            s1_vld   <= 1'b0;
            s1_start <= 1'b0;
        end else begin
            s1_vld   <= dinVld;
            s1_start <= dinVld & rowStart;
            if (dinVld) begin
                v0 <= relu(smax(din0, din1));
                v1 <= relu(smax(din2, din3));
            end
        end
    end

    // Stage 2: horizontal max across beat pairs, beat counting, error tracking.
    always_ff @(posedge clk_cal) begin
        if (rst_cal) begin
            hold0    <= '0;
            hold1    <= '0;
            parity   <= 1'b0;
            beat_cnt <= '0;
            pool0    <= '0;
            pool1    <= '0;
            poolVld  <= 1'b0;
            rowDone  <= 1'b0;
            pairErr  <= 1'b0;
        end else begin
            poolVld <= 1'b0;
            rowDone <= 1'b0;
            if (s1_vld) begin
                if (s1_start) begin
                    // Restart the row: any pending half pair is dropped and flagged.
                    if (parity) begin
                        pairErr <= 1'b1;
                    end
                    hold0    <= v0;
                    hold1    <= v1;
                    parity   <= 1'b1;
                    beat_cnt <= CW'(1);
                end else begin
                    beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
                    if (!parity) begin
                        hold0  <= v0;
                        hold1  <= v1;
                        parity <= 1'b1;
                    end else begin
                        pool0   <= umax(hold0, v0);
                        pool1   <= umax(hold1, v1);
                        poolVld <= 1'b1;
                        rowDone <= (beat_cnt == LAST_BEAT);
                        parity  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
